// File: rtl/ibex_crypto_issue_if.sv
// ibex_crypto_issue_if: decode-side, EX-side and writeback signals of the Zknh issue controller.
interface ibex_crypto_issue_if;
    logic        instr_valid;
    logic [31:0] instr_rdata;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_result;
    logic        crypto_hit;
    logic        illegal;
    logic        sha2_en;
    logic [3:0]  sha2_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        timeout;

    modport master (
        output instr_valid, instr_rdata, rs1_rdata, rs2_rdata, flush, ex_valid, ex_result,
        input  crypto_hit, illegal, sha2_en, sha2_op, op_a, op_b, stall, rf_we, rf_waddr,
               rf_wdata, timeout
    );

    modport slave (
        input  instr_valid, instr_rdata, rs1_rdata, rs2_rdata, flush, ex_valid, ex_result,
        output crypto_hit, illegal, sha2_en, sha2_op, op_a, op_b, stall, rf_we, rf_waddr,
               rf_wdata, timeout
    );
endinterface

// File: rtl/ibex_crypto_issue.sv
// ibex_crypto_issue: decodes Zknh SHA-2 ops, issues them to EX, waits for the result and writes it back.
module ibex_crypto_issue #(
    parameter bit          Sha512En  = 1'b1,
    parameter int unsigned WaitLimit = 15
) (
    input logic                 clk_i,
    input logic                 rst_i,
    ibex_crypto_issue_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    state_t      state, state_nxt;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [11:0] imm;
    logic        is_256;
    logic        is_512;
    logic [3:0]  dec_op;
    logic        accept;
    logic        busy;
    logic        tmo_hit;
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic [3:0]  op_q;
    logic [4:0]  rd_q;
    logic [31:0] result_q;
    logic [7:0]  wait_cnt;
    logic        timeout_q;

    assign opcode = bus.instr_rdata[6:0];
    assign funct3 = bus.instr_rdata[14:12];
    assign imm    = bus.instr_rdata[31:20];
    assign funct7 = bus.instr_rdata[31:25];

    // funct7 0101100/0101101 are not SHA-512 ops, hence the bit-2/bit-1 exclusion
    assign is_256 = (opcode == 7'b0010011) && (funct3 == 3'b001) && (imm[11:2] == 10'h040);
    assign is_512 = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7[6:3] == 4'b0101) &&
                    !(funct7[2] && !funct7[1]);
    assign dec_op = is_256 ? {2'b00, imm[1:0]} :
                    funct7[2] ? {3'b100, funct7[0]} : {2'b01, funct7[1:0]};

    assign bus.crypto_hit = is_256 || (is_512 && Sha512En);
    assign bus.illegal    = is_512 && !Sha512En;

    assign accept  = (state == IDLE) && bus.instr_valid && bus.crypto_hit && !bus.flush;
    assign busy    = (state == ISSUE) || (state == WAIT);
    assign tmo_hit = (state == WAIT) && !bus.flush && !bus.ex_valid &&
                     (wait_cnt == 8'(WaitLimit - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? ISSUE : IDLE;
            ISSUE:   state_nxt = bus.flush ? IDLE : bus.ex_valid ? WB : WAIT;
            WAIT:    state_nxt = bus.flush ? IDLE : bus.ex_valid ? WB : tmo_hit ? IDLE : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    // wait_cnt is held at zero outside WAIT, so it always starts from zero on entry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            result_q  <= '0;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                op_a_q <= bus.rs1_rdata;
                op_b_q <= bus.rs2_rdata;
                op_q   <= dec_op;
                rd_q   <= bus.instr_rdata[11:7];
            end
            if (busy && bus.ex_valid && !bus.flush) result_q <= bus.ex_result;
            wait_cnt  <= (state != WAIT) ? '0 :
                         (wait_cnt == 8'(WaitLimit)) ? wait_cnt : wait_cnt + 8'd1;
            timeout_q <= tmo_hit;
        end
    end

    assign bus.sha2_en  = busy;
    assign bus.sha2_op  = op_q;
    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;
    assign bus.stall    = accept || busy;
    assign bus.rf_we    = (state == WB) && (rd_q != 5'd0);
    assign bus.rf_waddr = rd_q;
    assign bus.rf_wdata = result_q;
    assign bus.timeout  = timeout_q;
endmodule
